siso_loopback_ctrl: RTL

Two-requester scheduler and sequencer for the shared N-stage serial-in/serial-out shift register. It arbitrates round-robin between two parallel-word requesters and serializes the granted word LSB-first into the shift register. It then deserializes the word returning from the shift register's output and hands it back with the requester ID and a loopback-compare flag. It sits directly in front of the shift register, drives its serial input and samples its serial output.

---
 rtl/siso_loopback_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/siso_loopback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : siso_loopback_ctrl
// Purpose  : Round-robin scheduler and sequencer in front of a shared N-stage
//            serial-in/serial-out shift register. A granted parallel word is
//            sent LSB-first, followed by N flush zeros. The word coming back
//            out of the shift register is rebuilt and returned with the
//            requester ID and a loopback-compare flag.
// Ports    : clk, rst         - clock and asynchronous active-high reset,
//                               both shared with the shift register
//            req0_* / req1_*  - valid/ready/data for each requester
//            siso_in          - serial bit driven into the shift register
//            siso_out         - serial bit sampled from the shift register
//            rsp_*            - response: valid/ready, returned word,
//                               owning requester ID, compare-error flag
//            busy             - high whenever the block is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module siso_loopback_ctrl #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         siso_in,
  input  logic         siso_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic         busy
);

  localparam int CW = $clog2(W + N + 1);
  localparam logic [CW-1:0] C_LAST = CW'(W + N - 1);
  localparam logic [CW-1:0] C_CAP  = CW'(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_tx;    // word as sent, kept for the loopback compare
  logic [W-1:0]    r_sh;    // working copy shifted out LSB-first
  logic [W-1:0]    r_rx;    // word rebuilt from siso_out
  logic            r_id;
  logic            r_last;  // requester granted most recently

  logic            w_idle;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_acc;

  // Requester 1 wins when it is the only one asking, or when both ask and
  // requester 0 had the previous grant.
  assign w_idle = (r_state == IDLE);
  assign w_gnt1 = req1_valid && (!req0_valid || !r_last);
  assign w_gnt0 = req0_valid && !w_gnt1;
  assign w_acc  = w_idle && (w_gnt0 || w_gnt1);

  assign req0_ready = w_idle && w_gnt0;
  assign req1_ready = w_idle && w_gnt1;

  // r_sh shifts in zeros, so once the W data bits are gone its LSB supplies
  // the flush zeros without any extra count comparison.
  assign siso_in   = (r_state == SHIFT) && r_sh[0];
  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_rx;
  assign rsp_id    = r_id;
  assign rsp_err   = (r_state == RESP) && (r_rx != r_tx);
  assign busy      = !w_idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tx    <= '0;
      r_sh    <= '0;
      r_rx    <= '0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_tx    <= w_gnt1 ? req1_data : req0_data;
            r_sh    <= w_gnt1 ? req1_data : req0_data;
            r_id    <= w_gnt1;
            r_last  <= w_gnt1;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sh <= r_sh >> 1;
          // Bit k sent in cycle k reappears in cycle k+N; filling from the
          // top leaves the first returned bit in the LSB after W captures.
          if (r_cnt >= C_CAP) begin
            r_rx <= (r_rx >> 1) | (W'(siso_out) << (W - 1));
          end
          if (r_cnt == C_LAST) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
